instruction_fetch: RTL and testbench

Instruction fetch (IF) stage of the pipelined MIPS core, directly upstream of the decode stage. It holds the program counter and a word-addressed instruction memory that the debug unit loads. Each enabled cycle it fetches one instruction into the IF/ID pipeline register. It applies next-PC redirection, stalls and flushes driven by decode, and freezes itself when it fetches a HALT instruction.

---
 rtl/instruction_fetch_pkg.sv | 27 ++
 rtl/instruction_fetch_if.sv | 39 +++
 rtl/instruction_fetch_instruction_memory.sv | 29 ++
 rtl/instruction_fetch.sv | 83 ++++++++
 tb/tb_instruction_fetch.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch stage.
//   NB_DATA / NB_ADDR / NB_OPCODE : word, address and opcode widths
//   OP_HALT, opcode bit range, NOP encoding, PC-source select codes
package instruction_fetch_pkg;

  localparam int NB_DATA   = 32;
  localparam int NB_ADDR   = 8;
  localparam int NB_OPCODE = 6;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [NB_OPCODE-1:0] OP_HALT = 6'b111111;
  localparam logic [NB_DATA-1:0]   NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SRC_NEXT   = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_REG    = 2'b11
  } pc_src_e;

  function automatic logic is_halt(input logic [NB_DATA-1:0] i_word);
    return i_word[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, loader and IF/ID bus of the fetch stage.
//   master : debug unit / decode side (drives i_*, observes o_*)
//   slave  : the fetch stage itself
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int P_NB_DATA = NB_DATA,
  parameter int P_NB_ADDR = NB_ADDR
);
  logic                 i_enable;
  logic                 i_pc_write;
  logic                 i_IF_ID_write;
  logic                 i_branch_or_jump;
  logic [1:0]           i_pc_src;
  logic [P_NB_ADDR-1:0] i_addr_branch;
  logic [P_NB_ADDR-1:0] i_addr_jump;
  logic [P_NB_ADDR-1:0] i_addr_register;
  logic                 i_mem_write;
  logic [P_NB_ADDR-1:0] i_mem_addr;
  logic [P_NB_DATA-1:0] i_mem_data;
  logic [P_NB_DATA-1:0] o_instruction;
  logic [P_NB_ADDR-1:0] o_pc;
  logic [P_NB_ADDR-1:0] o_pc_current;
  logic                 o_halt;

  modport master (
    output i_enable, i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
           i_addr_branch, i_addr_jump, i_addr_register,
           i_mem_write, i_mem_addr, i_mem_data,
    input  o_instruction, o_pc, o_pc_current, o_halt
  );

  modport slave (
    input  i_enable, i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
           i_addr_branch, i_addr_jump, i_addr_register,
           i_mem_write, i_mem_addr, i_mem_data,
    output o_instruction, o_pc, o_pc_current, o_halt
  );
endinterface

// File: rtl/instruction_fetch_instruction_memory.sv
// Word-addressed instruction memory, 2**NB_ADDR x NB_DATA.
//   i_clock      : write clock
//   i_write_en   : write strobe
//   i_write_addr : write word address
//   i_write_data : write word
//   i_read_addr  : combinational read address
//   o_read_data  : word at i_read_addr
// Contents are not reset.
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clock,
  input  logic               i_write_en,
  input  logic [NB_ADDR-1:0] i_write_addr,
  input  logic [NB_DATA-1:0] i_write_data,
  input  logic [NB_ADDR-1:0] i_read_addr,
  output logic [NB_DATA-1:0] o_read_data
);

  logic [NB_DATA-1:0] r_mem [0:(1<<NB_ADDR)-1];

  always_ff @(posedge i_clock) begin
    if (i_write_en) r_mem[i_write_addr] <= i_write_data;
  end

  assign o_read_data = r_mem[i_read_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC mux, IF/ID register and HALT freeze.
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-low reset (PC, IF/ID, halt -> 0)
//   if_bus  : control inputs, loader port and IF/ID outputs (slave side)
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  instruction_fetch_if.slave   if_bus
);

  logic [NB_ADDR-1:0] r_pc;
  logic [NB_DATA-1:0] r_instruction;
  logic [NB_ADDR-1:0] r_if_pc;
  logic               r_halt;

  logic [NB_DATA-1:0] w_fetched;
  logic [NB_ADDR-1:0] w_pc_inc;
  logic [NB_ADDR-1:0] w_pc_target;
  logic               w_mem_we;

  // The loader may only touch memory while the pipeline is stopped.
  assign w_mem_we = if_bus.i_mem_write & ~if_bus.i_enable;

  instruction_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .i_clock      (i_clock),
    .i_write_en   (w_mem_we),
    .i_write_addr (if_bus.i_mem_addr),
    .i_write_data (if_bus.i_mem_data),
    .i_read_addr  (r_pc),
    .o_read_data  (w_fetched)
  );

  assign w_pc_inc = r_pc + NB_ADDR'(1);

  // A redirect with the NEXT code falls back to sequential fetch.
  always_comb begin
    w_pc_target = w_pc_inc;
    case (if_bus.i_pc_src)
      PC_SRC_BRANCH: w_pc_target = if_bus.i_addr_branch;
      PC_SRC_JUMP:   w_pc_target = if_bus.i_addr_jump;
      PC_SRC_REG:    w_pc_target = if_bus.i_addr_register;
      default:       w_pc_target = w_pc_inc;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pc          <= '0;
      r_instruction <= NOP;
      r_if_pc       <= '0;
      r_halt        <= 1'b0;
    end else if (if_bus.i_enable) begin
      if (r_halt) begin
        r_instruction <= NOP;
        r_if_pc       <= '0;
      end else if (is_halt(w_fetched)) begin
        // HALT overrides stalls and redirects; the PC freezes on it.
        r_instruction <= w_fetched;
        r_if_pc       <= w_pc_inc;
        r_halt        <= 1'b1;
      end else begin
        if (if_bus.i_pc_write)
          r_pc <= if_bus.i_branch_or_jump ? w_pc_target : w_pc_inc;
        if (if_bus.i_IF_ID_write) begin
          // No delay slot: the word behind a taken redirect is flushed.
          r_instruction <= if_bus.i_branch_or_jump ? NOP : w_fetched;
          r_if_pc       <= if_bus.i_branch_or_jump ? '0 : w_pc_inc;
        end
      end
    end
  end

  assign if_bus.o_instruction = r_instruction;
  assign if_bus.o_pc          = r_if_pc;
  assign if_bus.o_pc_current  = r_pc;
  assign if_bus.o_halt        = r_halt;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 i_clock = ~i_clock;

  instruction_fetch_if bus ();

  instruction_fetch u_dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .if_bus  (bus)
  );

  typedef struct packed {
    logic        en;
    logic        pw;
    logic        iw;
    logic        bj;
    logic [1:0]  src;
    logic [7:0]  br;
    logic [7:0]  jmp;
    logic [7:0]  rg;
    logic [31:0] e_instr;
    logic [7:0]  e_pc;
    logic [7:0]  e_pcur;
    logic        e_halt;
  } vec_t;

  localparam int N_VEC = 18;
  vec_t vecs [N_VEC];

  function automatic vec_t mk(input logic en, pw, iw, bj, input logic [1:0] src,
                              input logic [7:0] br, jmp, rg,
                              input logic [31:0] e_instr, input logic [7:0] e_pc,
                              input logic [7:0] e_pcur, input logic e_halt);
    vec_t v;
    v.en = en; v.pw = pw; v.iw = iw; v.bj = bj; v.src = src;
    v.br = br; v.jmp = jmp; v.rg = rg;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_pcur = e_pcur; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] e_instr,
                           input logic [7:0] e_pc, input logic [7:0] e_pcur,
                           input logic e_halt);
    check({name, ".instr"}, bus.o_instruction, e_instr);
    check({name, ".pc"},    32'(bus.o_pc), 32'(e_pc));
    check({name, ".pcur"},  32'(bus.o_pc_current), 32'(e_pcur));
    check({name, ".halt"},  32'(bus.o_halt), 32'(e_halt));
  endtask

  task automatic drive(input logic en, pw, iw, bj, input logic [1:0] src,
                       input logic [7:0] br, jmp, rg);
    bus.i_enable         = en;
    bus.i_pc_write       = pw;
    bus.i_IF_ID_write    = iw;
    bus.i_branch_or_jump = bj;
    bus.i_pc_src         = src;
    bus.i_addr_branch    = br;
    bus.i_addr_jump      = jmp;
    bus.i_addr_register  = rg;
  endtask

  // One enabled-or-not clock: inputs set at negedge, outputs sampled at the next negedge.
  task automatic step(input logic en, pw, iw, bj, input logic [1:0] src,
                      input logic [7:0] br, jmp, rg);
    drive(en, pw, iw, bj, src, br, jmp, rg);
    @(negedge i_clock);
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h50, 8'h60, 8'h70);
    bus.i_mem_write = 1'b1;
    bus.i_mem_addr  = addr;
    bus.i_mem_data  = data;
    @(negedge i_clock);
    bus.i_mem_write = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 i_reset = 1'b0;
    #1;
    check_all("reset_pulse", 32'h0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 8'h50, 8'h60, 8'h70);
    #1 i_reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(1,1,1,0,2'd0, 8'h50,8'h60,8'h70, 32'h11,   8'h01, 8'h01, 0);
    vecs[1]  = mk(1,1,1,0,2'd0, 8'h50,8'h60,8'h70, 32'h22,   8'h02, 8'h02, 0);
    vecs[2]  = mk(1,0,0,0,2'd0, 8'h50,8'h60,8'h70, 32'h22,   8'h02, 8'h02, 0);
    vecs[3]  = mk(1,0,0,0,2'd0, 8'h50,8'h60,8'h70, 32'h22,   8'h02, 8'h02, 0);
    vecs[4]  = mk(1,1,1,0,2'd0, 8'h50,8'h60,8'h70, 32'h33,   8'h03, 8'h03, 0);
    vecs[5]  = mk(1,1,1,1,2'd2, 8'h50,8'h01,8'h70, 32'h0,    8'h00, 8'h01, 0);
    vecs[6]  = mk(1,1,1,1,2'd1, 8'h20,8'h60,8'h70, 32'h0,    8'h00, 8'h20, 0);
    vecs[7]  = mk(1,1,1,0,2'd0, 8'h50,8'h60,8'h70, 32'hA20,  8'h21, 8'h21, 0);
    vecs[8]  = mk(1,1,1,1,2'd2, 8'h50,8'h30,8'h70, 32'h0,    8'h00, 8'h30, 0);
    vecs[9]  = mk(1,1,1,0,2'd0, 8'h50,8'h60,8'h70, 32'hA30,  8'h31, 8'h31, 0);
    vecs[10] = mk(1,1,1,1,2'd3, 8'h50,8'h60,8'h40, 32'h0,    8'h00, 8'h40, 0);
    vecs[11] = mk(1,1,1,0,2'd0, 8'h50,8'h60,8'h70, 32'hA40,  8'h41, 8'h41, 0);
    vecs[12] = mk(1,1,1,1,2'd0, 8'h50,8'h60,8'h70, 32'h0,    8'h00, 8'h42, 0);
    vecs[13] = mk(1,1,1,0,2'd0, 8'h50,8'h60,8'h70, 32'h1042, 8'h43, 8'h43, 0);
    vecs[14] = mk(1,0,0,1,2'd2, 8'h50,8'h10,8'h70, 32'h1042, 8'h43, 8'h43, 0);
    vecs[15] = mk(1,1,0,0,2'd0, 8'h50,8'h60,8'h70, 32'h1042, 8'h43, 8'h44, 0);
    vecs[16] = mk(1,0,1,0,2'd0, 8'h50,8'h60,8'h70, 32'h1044, 8'h45, 8'h44, 0);
    vecs[17] = mk(0,1,1,1,2'd1, 8'h50,8'h60,8'h70, 32'h1044, 8'h45, 8'h44, 0);

    bus.i_mem_write = 1'b0;
    bus.i_mem_addr  = '0;
    bus.i_mem_data  = '0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h50, 8'h60, 8'h70);

    // Reset held from time zero.
    @(negedge i_clock);
    @(negedge i_clock);
    check_all("reset", 32'h0, 8'h00, 8'h00, 1'b0);
    i_reset = 1'b1;

    // Fill the whole memory with non-HALT words, then the program words.
    for (int a = 0; a < 256; a++) load(8'(a), 32'h1000 + 32'(a));
    load(8'h00, 32'h11);
    load(8'h01, 32'h22);
    load(8'h02, 32'h33);
    load(8'h03, 32'h44);
    load(8'h20, 32'hA20);
    load(8'h30, 32'hA30);
    load(8'h40, 32'hA40);
    check_all("loaded_idle", 32'h0, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < N_VEC; i++) begin
      step(vecs[i].en, vecs[i].pw, vecs[i].iw, vecs[i].bj, vecs[i].src,
           vecs[i].br, vecs[i].jmp, vecs[i].rg);
      check_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc,
                vecs[i].e_pcur, vecs[i].e_halt);
    end

    // Loader writes while enabled must be dropped.
    bus.i_mem_write = 1'b1;
    bus.i_mem_addr  = 8'h05;
    bus.i_mem_data  = 32'hDEAD_BEEF;
    step(1, 1, 1, 1, 2'd2, 8'h50, 8'h05, 8'h70);
    check_all("wr_en_redir", 32'h0, 8'h00, 8'h05, 1'b0);
    step(1, 1, 1, 0, 2'd0, 8'h50, 8'h60, 8'h70);
    check_all("wr_en_fetch5", 32'h1005, 8'h06, 8'h06, 1'b0);
    bus.i_mem_write = 1'b0;

    // Write to the current PC is seen by the next fetch.
    load(8'h06, 32'h6666);
    step(1, 1, 1, 0, 2'd0, 8'h50, 8'h60, 8'h70);
    check_all("wr_cur_pc", 32'h6666, 8'h07, 8'h07, 1'b0);

    // HALT at address 3.
    load(8'h03, 32'hFC00_0003);
    step(1, 1, 1, 1, 2'd2, 8'h50, 8'h03, 8'h70);
    check_all("pre_halt", 32'h0, 8'h00, 8'h03, 1'b0);
    step(1, 1, 1, 0, 2'd0, 8'h50, 8'h60, 8'h70);
    check_all("halt_edge", 32'hFC00_0003, 8'h04, 8'h03, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1, 1, 2'(k + 1), 8'h20, 8'h30, 8'h40);
      check({$sformatf("halted%0d", k), ".instr"}, bus.o_instruction, 32'h0);
      check({$sformatf("halted%0d", k), ".pcur"}, 32'(bus.o_pc_current), 32'h03);
      check({$sformatf("halted%0d", k), ".halt"}, 32'(bus.o_halt), 32'h1);
    end

    // Clear the halt, move to PC=0x20, then reset between edges mid-redirect.
    reset_pulse();
    @(negedge i_clock);
    check_all("after_pulse", 32'h11, 8'h01, 8'h01, 1'b0);
    step(1, 1, 1, 1, 2'd2, 8'h50, 8'h1F, 8'h70);
    check_all("to_1f", 32'h0, 8'h00, 8'h1F, 1'b0);
    step(1, 1, 1, 0, 2'd0, 8'h50, 8'h60, 8'h70);
    check_all("at_20", 32'h101F, 8'h20, 8'h20, 1'b0);
    drive(1, 1, 1, 1, 2'd2, 8'h50, 8'h30, 8'h70);
    reset_pulse();
    @(negedge i_clock);
    check_all("restart0", 32'h11, 8'h01, 8'h01, 1'b0);
    step(1, 1, 1, 0, 2'd0, 8'h50, 8'h60, 8'h70);
    check_all("restart1", 32'h22, 8'h02, 8'h02, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
